// File: rtl/mem_wrapper_dp.sv
// Simple-dual-port synchronous RAM with byte enables, write-first collision
// bypass, 1- or 2-cycle read latency and optional post-reset array clear.
module mem_wrapper_dp #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 1 << ADDR_WIDTH,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in, rd_in, wr_ok, rd_ok, collide;
  logic [DATA_WIDTH-1:0] rd_old, rd_word;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;

  assign init_busy = (state == CLEAR);
  assign wr_in     = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in     = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_ok     = (state == READY) && wr_en && wr_in;
  assign rd_ok     = (state == READY) && rd_en;
  assign collide   = wr_ok && (wr_addr == rd_addr);
  assign rd_old    = mem[rd_addr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET != 0) state <= CLEAR;
      else                     state <= READY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == LAST) state_nxt = READY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + 1'b1;
  end

  // Array itself carries no reset; clearing is the FSM's job.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (wr_ok) begin
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
          if (wr_be[i]) mem[wr_addr[IW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first merge; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        rd_word[8*i +: 8] = (collide && wr_be[i]) ? wr_data[8*i +: 8] : rd_old[8*i +: 8];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
        end else begin
          s1_valid <= rd_ok;
          if (rd_ok) s1_data <= rd_word;
        end
      end
      assign pipe_valid = s1_valid;
      assign pipe_data  = s1_data;
    end else begin : g_lat1
      assign pipe_valid = rd_ok;
      assign pipe_data  = rd_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pipe_valid;
      if (pipe_valid) rd_data <= pipe_data;
    end
  end

endmodule

// File: tb/tb_mem_wrapper_dp.sv
// Bench for mem_wrapper_dp: latency-1 and latency-2 instances share stimulus;
// each has its own scoreboard queue of expected data and arrival cycle.
module tb_mem_wrapper_dp;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [4:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;

  logic        busy1, busy2, val1, val2;
  logic [15:0] data1, data2;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  exp_t        q1[$], q2[$];
  logic [15:0] mdl [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_wrapper_dp #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .DEPTH(16), .RD_LATENCY(1),
                   .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data1), .rd_valid(val1));

  mem_wrapper_dp #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .DEPTH(16), .RD_LATENCY(2),
                   .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data2), .rd_valid(val2));

  // Output monitors: every rd_valid must match the oldest expected entry, on time.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0 && q1[0].cyc < cyc) begin
      e = q1.pop_front();
      checks++; failures++;
      $display("FAIL lat1_missing: no rd_valid at cycle %0d, required data %h", e.cyc, e.data);
    end
    if (val1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL lat1_unexpected: rd_valid=1 data=%h at cycle %0d, required no read", data1, cyc);
      end else begin
        e = q1.pop_front();
        if (data1 !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL lat1_read: data=%h cycle=%0d, required data=%h cycle=%0d", data1, cyc, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q2.size() > 0 && q2[0].cyc < cyc) begin
      e = q2.pop_front();
      checks++; failures++;
      $display("FAIL lat2_missing: no rd_valid at cycle %0d, required data %h", e.cyc, e.data);
    end
    if (val2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL lat2_unexpected: rd_valid=1 data=%h at cycle %0d, required no read", data2, cyc);
      end else begin
        e = q2.pop_front();
        if (data2 !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL lat2_read: data=%h cycle=%0d, required data=%h cycle=%0d", data2, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; the request is sampled at the next edge.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [4:0] ra,
                       input bit live);
    logic [15:0] mask, e;
    exp_t        ent;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    mask = {{8{be[1]}}, {8{be[0]}}};
    if (live && re) begin
      if (ra >= 5'd16) e = 16'h0000;
      else if (we && wa == ra) e = (mdl[ra[3:0]] & ~mask) | (wd & mask);
      else e = mdl[ra[3:0]];
      ent.data = e; ent.cyc = cyc + 1; q1.push_back(ent);
      ent.cyc = cyc + 2; q2.push_back(ent);
    end
    if (live && we && wa < 5'd16)
      mdl[wa[3:0]] = (mdl[wa[3:0]] & ~mask) | (wd & mask);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  // One reset edge; reads that would complete after it are dropped.
  task automatic do_reset();
    rst_n = 1'b0;
    while (q1.size() > 0 && q1[$].cyc > cyc) void'(q1.pop_back());
    while (q2.size() > 0 && q2[$].cyc > cyc) void'(q2.pop_back());
    wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Starts right after the last reset edge; issues ignored junk while busy.
  task automatic count_clear(input string tag);
    int n1 = 0, n2 = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy1 !== 1'b1 && busy2 !== 1'b1) break;
      if (busy1 === 1'b1) n1++;
      if (busy2 === 1'b1) n2++;
      drive(1'b1, 5'($urandom_range(0, 15)), 16'($urandom), 2'b11, 1'b1,
            5'($urandom_range(0, 15)), 1'b0);
    end
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    checks++;
    if (n1 != 16) begin failures++; $display("FAIL %s_busy_lat1: busy cycles=%0d, required 16", tag, n1); end
    checks++;
    if (n2 != 16) begin failures++; $display("FAIL %s_busy_lat2: busy cycles=%0d, required 16", tag, n2); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      failures++; $display("FAIL reset_busy: init_busy=%b/%b, required 1/1", busy1, busy2);
    end
    checks++;
    if (val1 !== 1'b0 || val2 !== 1'b0) begin
      failures++; $display("FAIL reset_valid: rd_valid=%b/%b, required 0/0", val1, val2);
    end
    checks++;
    if (data1 !== 16'h0 || data2 !== 16'h0) begin
      failures++; $display("FAIL reset_data: rd_data=%h/%h, required 0000/0000", data1, data2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clear();
    count_clear("clear");
    for (int a = 0; a < 16; a++) drive(1'b0, '0, '0, '0, 1'b1, 5'(a), 1'b1);
    idle(3);
  endtask

  task automatic test_byte_write();
    drive(1'b1, 5'd5, 16'hABCD, 2'b11, 1'b0, '0, 1'b1);
    drive(1'b1, 5'd5, 16'h1234, 2'b01, 1'b0, '0, 1'b1);
    drive(1'b1, 5'd5, 16'h5555, 2'b00, 1'b0, '0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd5, 1'b1);
    idle(3);
  endtask

  task automatic test_collision();
    drive(1'b1, 5'd7, 16'h1111, 2'b11, 1'b0, '0, 1'b1);
    drive(1'b1, 5'd7, 16'hFF00, 2'b10, 1'b1, 5'd7, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b1);
    idle(3);
  endtask

  task automatic test_streaming();
    for (int i = 0; i <= 16; i++)
      drive(i < 16, 5'(i), 16'(i), 2'b11, i >= 1, 5'(i - 1), 1'b1);
    idle(3);
  endtask

  task automatic test_later_write();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b1);
    drive(1'b1, 5'd3, 16'hBEEF, 2'b11, 1'b0, '0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b1);
    idle(3);
  endtask

  task automatic test_range();
    drive(1'b1, 5'd20, 16'hDEAD, 2'b11, 1'b0, '0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd20, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd4, 1'b1);
    idle(3);
  endtask

  task automatic test_reset_mid_read();
    drive(1'b0, '0, '0, '0, 1'b1, 5'd5, 1'b1);
    do_reset();
    checks++;
    if (data1 !== 16'h0 || data2 !== 16'h0) begin
      failures++; $display("FAIL midread_data: rd_data=%h/%h, required 0000/0000", data1, data2);
    end
    count_clear("midread");
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 5'd5, 16'hAAAA, 2'b11, 1'b1, 5'd5, 1'b0);
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      failures++; $display("FAIL midclear_busy: init_busy=%b/%b at cnt=9, required 1/1", busy1, busy2);
    end
    do_reset();
    count_clear("midclear");
    drive(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd5, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 5'd15, 1'b1);
    idle(3);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    test_reset();
    test_clear();
    test_byte_write();
    test_collision();
    test_streaming();
    test_later_write();
    test_range();
    test_reset_mid_read();
    test_reset_mid_clear();
    idle(4);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      failures++; $display("FAIL drain: pending reads=%0d/%0d, required 0/0", q1.size(), q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
